// File: rtl/fetch_stage.sv
// fetch_stage: PC register plus IF/ID pipeline register with stall, flush, misalignment and flush-count tracking
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Instr_In,
  output logic [31:0] PC_Out,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        Misaligned_Target,
  output logic [15:0] Flush_Count
);
  logic [31:0] pc_q, pc_d, id_pc_q, id_pc_d, id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d, mis_q, mis_d;
  logic [15:0] fcnt_q, fcnt_d;
  // next state: a flush redirects and bubbles regardless of any stall request
  always_comb begin
    pc_d       = IF_Flush ? {Branch_Target[31:2], 2'b00} : PC_Write ? pc_q + 32'd4 : pc_q;
    id_pc_d    = (IF_Flush || IF_ID_Write) ? pc_q : id_pc_q;
    id_instr_d = IF_Flush ? NOP_INSTR : IF_ID_Write ? Instr_In : id_instr_q;
    id_valid_d = IF_Flush ? 1'b0 : IF_ID_Write ? 1'b1 : id_valid_q;
    mis_d      = mis_q | (IF_Flush & (Branch_Target[1:0] != 2'b00));
    fcnt_d     = (IF_Flush && fcnt_q != 16'hFFFF) ? fcnt_q + 16'd1 : fcnt_q;
  end
  // state registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      fcnt_q     <= 16'h0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      mis_q      <= mis_d;
      fcnt_q     <= fcnt_d;
    end
  end
  assign PC_Out            = pc_q;
  assign IF_ID_PC          = id_pc_q;
  assign IF_ID_Instr       = id_instr_q;
  assign IF_ID_Valid       = id_valid_q;
  assign Misaligned_Target = mis_q;
  assign Flush_Count       = fcnt_q;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction word injected on reset and flush.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-high; asserting it forces all state to reset values immediately.
REQ-005 PC_Write  in  1  SHALL enable PC advance; 0 = hazard-unit stall of the PC.
REQ-006 IF_ID_Write  in  1  SHALL enable the IF/ID register load; 0 = hazard-unit stall of IF/ID.
REQ-007 IF_Flush  in  1  SHALL be the taken-branch flush from the ID-stage branch comparator.
REQ-008 Branch_Target  in  32  SHALL be the redirect address, valid when IF_Flush=1.
REQ-009 Instr_In  in  32  SHALL be the instruction-memory read data for the current PC_Out, available in the same cycle.
REQ-010 PC_Out  out  32  SHALL be the current fetch address to instruction memory.
REQ-011 IF_ID_PC  out  32  SHALL be the PC of the instruction held in IF/ID.
REQ-012 IF_ID_Instr  out  32  SHALL be the instruction held in IF/ID.
REQ-013 IF_ID_Valid  out  1  SHALL be 1 when IF/ID holds a real fetched instruction, 0 for an injected bubble.
REQ-014 Misaligned_Target  out  1  SHALL be a sticky flag set by a redirect to a non-word-aligned target.
REQ-015 Flush_Count  out  16  SHALL count accepted flushes for performance monitoring.

Function
REQ-016 PC update priority per edge SHALL be: IF_Flush -> PC_Out <= {Branch_Target[31:2],2'b00}; else PC_Write -> PC_Out <= PC_Out+4; else hold.
REQ-017 PC+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000, no flag.
REQ-018 IF/ID priority per edge SHALL be: IF_Flush -> IF_ID_Instr<=NOP_INSTR, IF_ID_Valid<=0, IF_ID_PC<=PC_Out; else IF_ID_Write -> IF_ID_PC<=PC_Out, IF_ID_Instr<=Instr_In, IF_ID_Valid<=1; else hold all three.
REQ-019 IF_Flush SHALL override PC_Write=0 and IF_ID_Write=0 in the same cycle (flush beats stall).
REQ-020 Redirect latency SHALL be one cycle: flush sampled at edge N -> PC_Out=target after edge N; the target instruction appears in IF/ID after edge N+1 (given IF_ID_Write=1).
REQ-021 Exactly one bubble SHALL be inserted per flush cycle; consecutive flush cycles each insert one bubble and each redirect, the last one winning.
REQ-022 Misaligned_Target SHALL be set at an edge where IF_Flush=1 and Branch_Target[1:0]!=0, and SHALL remain 1 until reset.
REQ-023 Flush_Count SHALL increment by 1 on every edge with IF_Flush=1 and saturate at 16'hFFFF.
REQ-024 PC_Write=1 with IF_ID_Write=0 (and no flush) SHALL advance the PC and leave IF/ID unchanged; the skipped instruction is not captured (hazard unit must not issue this combination).
REQ-025 All outputs SHALL be driven directly from registers; no combinational path from any input to any output.

Reset
REQ-026 On reset assertion: PC_Out=RESET_PC, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, Misaligned_Target=0, Flush_Count=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending flush or stall; the first edge after deassertion with PC_Write=IF_ID_Write=1 captures Instr_In at RESET_PC with IF_ID_Valid=1 and PC_Out=RESET_PC+4.

Verification
REQ-028 Sequential fetch: reset, PC_Write=IF_ID_Write=1 for 4 cycles, Instr_In=PC-derived -> PC_Out 0,4,8,12,16; IF_ID_PC lags by one, IF_ID_Valid=1 after first edge.
REQ-029 Taken branch: at PC_Out=8 pulse IF_Flush with Branch_Target=32'h40 -> next: PC_Out=0x40, IF_ID_Instr=0x13, IF_ID_Valid=0; following edge IF_ID_PC=0x40, Valid=1; Flush_Count=1.
REQ-030 Stall: PC_Write=IF_ID_Write=0 for 3 cycles -> PC_Out and IF/ID unchanged; then flush during stall with target 0x80 -> PC_Out=0x80, bubble in IF/ID.
REQ-031 Misaligned: flush with Branch_Target=32'h0000_0102 -> PC_Out=0x100, Misaligned_Target=1, still 1 after 10 normal cycles, 0 after reset.
REQ-032 Wrap and saturate: flush to 0xFFFF_FFFC then advance -> PC_Out=0; force 65537 flushes -> Flush_Count=16'hFFFF.
REQ-033 Async reset: assert reset between clock edges while Valid=1 -> outputs reach reset values before the next rising edge.
